// File: rtl/vector_pkg.sv
// rtl/vector_pkg.sv - shared opcode constants and sequencer state type
package vector_pkg;

    localparam logic [4:0] OP_ADD   = 5'b00000;
    localparam logic [4:0] OP_SUB   = 5'b00001;
    localparam logic [4:0] OP_FXADD = 5'b01000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/vector_lane_sequencer.sv
// rtl/vector_lane_sequencer.sv - walks a vector op lane by lane through an external ALU
module vector_lane_sequencer
    import vector_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_LANES  = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [4:0]                       in_opcode,
    input  logic [$clog2(NUM_LANES)-1:0]     in_vl,
    input  logic [NUM_LANES*DATA_WIDTH-1:0]  in_vec_a,
    input  logic [NUM_LANES*DATA_WIDTH-1:0]  in_vec_b,
    output logic [DATA_WIDTH-1:0]            alu_operand1,
    output logic [DATA_WIDTH-1:0]            alu_operand2,
    output logic [4:0]                       alu_opcode,
    input  logic [DATA_WIDTH-1:0]            alu_result,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [NUM_LANES*DATA_WIDTH-1:0]  out_vec
);

    localparam int LANE_W = $clog2(NUM_LANES);
    localparam int VEC_W  = NUM_LANES * DATA_WIDTH;
    // vl is held one bit wider so that the full-length case (in_vl == 0) fits
    localparam logic [LANE_W:0] VL_ONE  = (LANE_W+1)'(1);
    localparam logic [LANE_W:0] VL_FULL = (LANE_W+1)'(NUM_LANES);

    state_e              state_q, state_d;
    logic [VEC_W-1:0]    a_q, b_q, res_q, res_d;
    logic [4:0]          op_q;
    logic [LANE_W:0]     vl_q;
    logic [LANE_W-1:0]   cnt_q;
    logic                handshake;
    logic                last_lane;

    assign handshake = in_valid && in_ready;
    assign last_lane = ({1'b0, cnt_q} == (vl_q - VL_ONE));
    assign alu_opcode = op_q;
    assign out_vec    = res_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (handshake) state_d = RUN;
            RUN:     if (last_lane) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake and ALU operand outputs; operands are zero outside RUN
    always_comb begin
        in_ready     = (state_q == IDLE) && rst_n;
        out_valid    = (state_q == DONE);
        alu_operand1 = '0;
        alu_operand2 = '0;
        if (state_q == RUN) begin
            alu_operand1 = a_q[cnt_q*DATA_WIDTH +: DATA_WIDTH];
            alu_operand2 = b_q[cnt_q*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Result vector with the current lane replaced by the ALU result
    always_comb begin
        res_d = res_q;
        res_d[cnt_q*DATA_WIDTH +: DATA_WIDTH] = alu_result;
    end

    // Operand latch, lane counter and result accumulation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= 5'b00000;
            vl_q  <= '0;
            cnt_q <= '0;
            res_q <= '0;
        end else if (handshake) begin
            a_q   <= in_vec_a;
            b_q   <= in_vec_b;
            op_q  <= in_opcode;
            vl_q  <= (in_vl == '0) ? VL_FULL : {1'b0, in_vl};
            cnt_q <= '0;
            res_q <= '0;
        end else if (state_q == RUN) begin
            res_q <= res_d;
            // Counter stops on the last lane so it never passes vl-1
            if (!last_lane) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vector_lane_sequencer.sv
// tb/tb_vector_lane_sequencer.sv - directed self-checking bench for vector_lane_sequencer
module tb_vector_lane_sequencer;
    import vector_pkg::*;

    localparam int DW = 16;
    localparam int NL = 16;
    localparam int LW = 4;
    localparam int VW = NL * DW;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [4:0]    in_opcode;
    logic [LW-1:0] in_vl;
    logic [VW-1:0] in_vec_a;
    logic [VW-1:0] in_vec_b;
    logic [DW-1:0] alu_operand1;
    logic [DW-1:0] alu_operand2;
    logic [4:0]    alu_opcode;
    logic [DW-1:0] alu_result;
    logic          out_valid;
    logic          out_ready;
    logic [VW-1:0] out_vec;

    int errors = 0;
    int checks = 0;
    int lat;
    logic [VW-1:0] va, vb, vexp;

    vector_lane_sequencer #(.DATA_WIDTH(DW), .NUM_LANES(NL)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_opcode    (in_opcode),
        .in_vl        (in_vl),
        .in_vec_a     (in_vec_a),
        .in_vec_b     (in_vec_b),
        .alu_operand1 (alu_operand1),
        .alu_operand2 (alu_operand2),
        .alu_opcode   (alu_opcode),
        .alu_result   (alu_result),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_vec      (out_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU model: subtract for OP_SUB, plain add for everything else
    always_comb begin
        if (alu_opcode == OP_SUB) alu_result = alu_operand1 - alu_operand2;
        else                      alu_result = alu_operand1 + alu_operand2;
    end

    function automatic logic [VW-1:0] put(input logic [VW-1:0] v, input int i, input logic [DW-1:0] x);
        logic [VW-1:0] r;
        r = v;
        r[i*DW +: DW] = x;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the handshake edge
    task automatic issue(input logic [4:0] op, input logic [LW-1:0] vl,
                         input logic [VW-1:0] a, input logic [VW-1:0] b);
        in_opcode = op;
        in_vl     = vl;
        in_vec_a  = a;
        in_vec_b  = b;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    // Counts edges from the handshake edge until out_valid is seen
    task automatic wait_done(output int n);
        n = 1;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
    endtask

    task automatic consume(input string tag);
        chk({tag, "_in_ready_done"}, VW'(in_ready), VW'(1'b0));
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_out_valid_after"}, VW'(out_valid), VW'(1'b0));
        chk({tag, "_in_ready_after"}, VW'(in_ready), VW'(1'b1));
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_opcode = '0;
        in_vl     = '0;
        in_vec_a  = '0;
        in_vec_b  = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_in_ready",  VW'(in_ready), VW'(1'b0));
        chk("rst_out_valid", VW'(out_valid), VW'(1'b0));
        chk("rst_out_vec",   out_vec, '0);
        chk("rst_op1",       VW'(alu_operand1), '0);
        chk("rst_opcode",    VW'(alu_opcode), '0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_in_ready",  VW'(in_ready), VW'(1'b1));

        // Full-length ADD, vl=0 means 16 lanes
        va = '0; vb = '0; vexp = '0;
        for (int i = 0; i < NL; i++) begin
            va   = put(va, i, DW'(i));
            vb   = put(vb, i, 16'h4000);
            vexp = put(vexp, i, 16'h4000 + DW'(i));
        end
        issue(OP_ADD, 4'd0, va, vb);
        wait_done(lat);
        chk("add_latency", VW'(lat), VW'(17));
        chk("add_out_vec", out_vec, vexp);
        consume("add");

        // Short SUB with a nonzero lane beyond vl that must not leak through
        va = '0; vb = '0; vexp = '0;
        va = put(va, 0, 16'd10); va = put(va, 1, 16'd20); va = put(va, 2, 16'd30);
        va = put(va, 5, 16'd99);
        vb = put(vb, 0, 16'd1);  vb = put(vb, 1, 16'd2);  vb = put(vb, 2, 16'd3);
        vexp = put(vexp, 0, 16'd9); vexp = put(vexp, 1, 16'd18); vexp = put(vexp, 2, 16'd27);
        issue(OP_SUB, 4'd3, va, vb);
        wait_done(lat);
        chk("sub_latency", VW'(lat), VW'(4));
        chk("sub_out_vec", out_vec, vexp);

        // Backpressure: hold out_ready low for 5 cycles in DONE
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp_out_valid", VW'(out_valid), VW'(1'b1));
            chk("bp_out_vec",   out_vec, vexp);
            chk("bp_in_ready",  VW'(in_ready), VW'(1'b0));
        end
        chk("bp_op1_zero", VW'(alu_operand1), '0);
        consume("sub");

        // Fixed-point ADD, single lane
        va = put('0, 0, 16'h0A80);
        vb = put('0, 0, 16'h01C0);
        vexp = put('0, 0, 16'h0C40);
        issue(OP_FXADD, 4'd1, va, vb);
        wait_done(lat);
        chk("fx_latency", VW'(lat), VW'(2));
        chk("fx_out_vec", out_vec, vexp);
        chk("fx_opcode",  VW'(alu_opcode), VW'(5'b01000));
        consume("fx");

        // in_valid toggling with new operands during RUN must be ignored
        va = '0; vb = '0; vexp = '0;
        for (int i = 0; i < 4; i++) begin
            va   = put(va, i, DW'(i + 1));
            vb   = put(vb, i, DW'(10 * (i + 1)));
            vexp = put(vexp, i, DW'(11 * (i + 1)));
        end
        issue(OP_ADD, 4'd4, va, vb);
        chk("tog_op1_lane0", VW'(alu_operand1), VW'(16'd1));
        chk("tog_op2_lane0", VW'(alu_operand2), VW'(16'd10));
        lat = 1;
        while (!out_valid && lat < 40) begin
            in_valid  = lat[0];
            in_opcode = OP_SUB;
            in_vl     = 4'd1;
            in_vec_a  = '1;
            in_vec_b  = '1;
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        chk("tog_latency", VW'(lat), VW'(5));
        chk("tog_out_vec", out_vec, vexp);
        chk("tog_opcode",  VW'(alu_opcode), VW'(OP_ADD));
        consume("tog");

        // Reset while RUN is working on lane 5
        va = '0; vb = '0;
        for (int i = 0; i < NL; i++) begin
            va = put(va, i, DW'(i));
            vb = put(vb, i, 16'h0100);
        end
        issue(OP_SUB, 4'd0, va, vb);
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("mid_lane5_op1", VW'(alu_operand1), VW'(16'd5));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", VW'(out_valid), VW'(1'b0));
        chk("mid_rst_out_vec",   out_vec, '0);
        chk("mid_rst_in_ready",  VW'(in_ready), VW'(1'b0));
        chk("mid_rst_op1",       VW'(alu_operand1), '0);
        chk("mid_rst_opcode",    VW'(alu_opcode), '0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mid_rel_in_ready", VW'(in_ready), VW'(1'b1));
        repeat (20) @(negedge clk);
        chk("mid_no_output",    VW'(out_valid), VW'(1'b0));
        chk("mid_out_vec_zero", out_vec, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
